mm_job_sequencer: RTL
=====================

MM_JOB_SEQUENCER -- requirements
Module: mm_job_sequencer

Interface
REQ-001 SHALL have parameter DW, default 2, operand element width in bits.
REQ-002 SHALL have parameter RW, default 4, per-lane result width in bits.
REQ-003 SHALL have parameter CALC_LAT, default 6, range 1..15, cycles from the operand issue to a valid multiplier result.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand element offered.
REQ-007 SHALL have port in_data  input  DW  operand element.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts an element this cycle.
REQ-009 SHALL have port reload_w  input  1  reload weights for the next job; sampled at the result handshake.
REQ-010 SHALL have port mm_start  output  1  one-cycle issue strobe to the multiplier.
REQ-011 SHALL have port mm_conf  output  1  qualifies mm_start: 1 = weight load, 0 = compute.
REQ-012 SHALL have ports mm_data0..mm_data3  output  DW each  registered operand lanes to the multiplier.
REQ-013 SHALL have ports mm_res0..mm_res3  input  RW each  multiplier result lanes.
REQ-014 SHALL have port res_valid  output  1  result word available.
REQ-015 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port res_data  output  4*RW  captured result {res0,res1,res2,res3}, with res0 in the MSBs.
REQ-017 SHALL have port busy  output  1  high in ISSUE_W, ISSUE_X, WAIT and OUT.
REQ-018 SHALL have port job_cnt  output  8  completed-job counter (see Configuration).

Function
REQ-019 SHALL implement states FILL_W, ISSUE_W, FILL_X, ISSUE_X, WAIT, OUT.
REQ-020 SHALL drive in_ready=1 only in FILL_W and FILL_X; an element is accepted when in_valid && in_ready.
REQ-021 SHALL write the k-th accepted element of a fill (k=0..3, 2-bit counter) into mm_data<k>; a fill only overwrites its own lanes, and lanes are held between fills.
REQ-022 SHALL, on the 4th acceptance in FILL_W, go to ISSUE_W, and on the 4th in FILL_X, go to ISSUE_X; the element counter clears on that cycle.
REQ-023 SHALL, in ISSUE_W, drive mm_start=1 and mm_conf=1 for exactly one cycle, then enter FILL_X.
REQ-024 SHALL, in ISSUE_X, drive mm_start=1 and mm_conf=0 for exactly one cycle, then enter WAIT.
REQ-025 SHALL drive mm_start=0 and mm_conf=0 in all other states.
REQ-026 SHALL stay in WAIT exactly CALC_LAT cycles, capture mm_res0..3 into res_data on the last WAIT edge, then enter OUT.
REQ-027 SHALL assert res_valid first CALC_LAT+1 cycles after the ISSUE_X cycle.
REQ-028 SHALL, in OUT, hold res_valid=1 and res_data stable until res_ready=1.
REQ-029 SHALL, on the res_valid && res_ready cycle, go to FILL_W if reload_w=1, else to FILL_X (weights reused).
REQ-030 SHALL ignore in_valid and in_data outside the FILL states, with no state change.
REQ-031 SHALL ignore res_ready outside OUT.
REQ-032 SHALL not write mm_data lanes in ISSUE, WAIT or OUT.

Reset
REQ-033 SHALL, on rst=0 at a clock edge, regardless of state (including mid-fill or WAIT), enter FILL_W and clear the element counter, the WAIT counter, mm_data0..3, res_data and job_cnt.
REQ-034 SHALL, while in reset, hold in_ready=0, mm_start=0, mm_conf=0, res_valid=0 and busy=0.
REQ-035 SHALL drive in_ready=1 from the first cycle after rst returns to 1.

Configuration
REQ-036 SHALL, with SEQ_JOB_CNT_EN defined, increment job_cnt by 1 on each result handshake, wrapping 255 -> 0.
REQ-037 SHALL, without SEQ_JOB_CNT_EN, tie job_cnt to 8'h00 and synthesize no counter register.

Verification
REQ-038 SHALL cover: reset, then elements 1,2,3,0 with in_valid held high -> mm_start+mm_conf pulse once, mm_data0..3 = 1,2,3,0, state FILL_X.
REQ-039 SHALL cover: full job with a model returning mm_res = A,B,C,D and CALC_LAT=6 -> res_valid rises 7 cycles after the mm_start (conf=0) cycle; res_data = 16'hABCD.
REQ-040 SHALL cover: res_ready held low 10 cycles in OUT -> res_valid and res_data stable, in_ready=0, in_valid pulses ignored.
REQ-041 SHALL cover: handshake with reload_w=0 -> next fill is FILL_X; mm_data lanes hold the weights until the new elements land; no conf=1 pulse.
REQ-042 SHALL cover: rst=0 asserted after 2 of 4 elements and again in WAIT -> state FILL_W, all outputs 0, and the next 4 elements produce a full weight fill.
REQ-043 SHALL cover: with SEQ_JOB_CNT_EN, 257 jobs -> job_cnt = 1; without the macro -> job_cnt = 0 throughout.

Source files
------------

// File: rtl/mm_job_sequencer.sv
// mm_job_sequencer: collects four weight elements and four operand elements,
// issues them to a 4-lane multiplier, waits CALC_LAT cycles, then holds the
// captured result until the consumer takes it.
//
// Optional feature: define SEQ_JOB_CNT_EN to build the completed-job counter;
// without it job_cnt is tied to zero.
//
// Handshakes: an element moves when in_valid && in_ready on a rising edge;
// a result moves when res_valid && res_ready on a rising edge. The producer
// and consumer may hold valid/ready high; nothing moves in other states.
module mm_job_sequencer #(
  parameter int DW       = 2,
  parameter int RW       = 4,
  parameter int CALC_LAT = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          reload_w,
  output logic          mm_start,
  output logic          mm_conf,
  output logic [DW-1:0] mm_data0,
  output logic [DW-1:0] mm_data1,
  output logic [DW-1:0] mm_data2,
  output logic [DW-1:0] mm_data3,
  input  logic [RW-1:0] mm_res0,
  input  logic [RW-1:0] mm_res1,
  input  logic [RW-1:0] mm_res2,
  input  logic [RW-1:0] mm_res3,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [4*RW-1:0] res_data,
  output logic          busy,
  output logic [7:0]    job_cnt,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    S_FILL_W  = 3'd0,
    S_ISSUE_W = 3'd1,
    S_FILL_X  = 3'd2,
    S_ISSUE_X = 3'd3,
    S_WAIT    = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(CALC_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] elem_cnt;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       last_elem;
  logic       wait_done;
  logic       handshake;

  assign accept    = in_valid && in_ready;
  assign last_elem = accept && (elem_cnt == 2'd3);
  assign wait_done = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
  assign handshake = res_valid && res_ready;
  assign fsm_state = state;

  // Next-state decode; outputs below are registered from this value so they
  // line up with the state register and stay low throughout reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL_W:  if (last_elem) state_nxt = S_ISSUE_W;
      S_ISSUE_W: state_nxt = S_FILL_X;
      S_FILL_X:  if (last_elem) state_nxt = S_ISSUE_X;
      S_ISSUE_X: state_nxt = S_WAIT;
      S_WAIT:    if (wait_done) state_nxt = S_OUT;
      S_OUT:     if (handshake) state_nxt = reload_w ? S_FILL_W : S_FILL_X;
      default:   state_nxt = S_FILL_W;
    endcase
  end

  // State register, registered outputs, element lanes, wait timer and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FILL_W;
      elem_cnt  <= 2'd0;
      wait_cnt  <= 4'd0;
      mm_data0  <= '0;
      mm_data1  <= '0;
      mm_data2  <= '0;
      mm_data3  <= '0;
      res_data  <= '0;
      in_ready  <= 1'b0;
      mm_start  <= 1'b0;
      mm_conf   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_FILL_W) || (state_nxt == S_FILL_X);
      mm_start  <= (state_nxt == S_ISSUE_W) || (state_nxt == S_ISSUE_X);
      mm_conf   <= (state_nxt == S_ISSUE_W);
      res_valid <= (state_nxt == S_OUT);
      busy      <= (state_nxt == S_ISSUE_W) || (state_nxt == S_ISSUE_X) ||
                   (state_nxt == S_WAIT) || (state_nxt == S_OUT);

      // in_ready is only high in the fill states, so lanes cannot change elsewhere.
      if (accept) begin
        elem_cnt <= elem_cnt + 2'd1;
        case (elem_cnt)
          2'd0:    mm_data0 <= in_data;
          2'd1:    mm_data1 <= in_data;
          2'd2:    mm_data2 <= in_data;
          default: mm_data3 <= in_data;
        endcase
      end

      wait_cnt <= ((state == S_WAIT) && !wait_done) ? wait_cnt + 4'd1 : 4'd0;
      if (wait_done) res_data <= {mm_res0, mm_res1, mm_res2, mm_res3};
    end
  end

`ifdef SEQ_JOB_CNT_EN
  // Completed-job counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst) job_cnt <= 8'h00;
    else if (handshake) job_cnt <= job_cnt + 8'h01;
  end
`else
  assign job_cnt = 8'h00;
`endif

endmodule
